// File: rtl/dds_poly_if.sv
// Command channel of the polyphonic DDS: one command per clock, qualified by
// cmd_valid && cmd_ready.
interface dds_poly_if #(
    parameter int VOICES  = 8,
    parameter int PHASE_W = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [$clog2(VOICES)-1:0] cmd_voice;
    logic [PHASE_W-1:0]        cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_voice, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_voice, cmd_data, output cmd_ready);
endinterface

// File: rtl/dds_poly.sv
// Polyphonic wavetable DDS: sweeps all voices through an external ROM once per sample
// tick and mixes them to an R2R DAC word. Define DDS_VELOCITY_EN for per-voice velocity.
module dds_poly #(
    parameter int VOICES   = 8,
    parameter int PHASE_W  = 32,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 24,
    parameter int OUT_W    = 8,
    parameter int DIV      = 100
) (
    input  logic                clk,
    input  logic                reset,
    dds_poly_if.slave           cmd,
    output logic [ADDR_W+2:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    output logic [OUT_W-1:0]    R2R_out,
    output logic                sample_valid,
    output logic [VOICES-1:0]   voice_active
);
    localparam int VW    = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int DIV_W = $clog2(DIV);
`ifdef DDS_VELOCITY_EN
    localparam int DRAIN_N = 2;
`else
    localparam int DRAIN_N = 1;
`endif
    localparam logic [VW-1:0] LAST_FETCH = VW'(VOICES - 1);
    localparam logic [VW-1:0] LAST_DRAIN = VW'(DRAIN_N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]          state_q;
    logic [DIV_W-1:0]    div_q;
    logic [VW-1:0]       idx_q;
    logic [PHASE_W-1:0]  phase_q [VOICES];
    logic [PHASE_W-1:0]  phase_d [VOICES];
    logic [PHASE_W-1:0]  ftw_q   [VOICES];
    logic [PHASE_W-1:0]  ftw_d   [VOICES];
    logic [2:0]          wave_q  [VOICES];
    logic [2:0]          wave_d  [VOICES];
    logic [VOICES-1:0]   active_q, active_d;
    logic [ACC_W-1:0]    acc_q, addend, sum;
    logic [OUT_W-1:0]    r2r_q;
    logic                valid_q;
    logic [ADDR_W+2:0]   romAddr_q;
    logic                fetchAct_q, addAct_q;
    logic                tick, fetchLoad;
    logic [VW-1:0]       fetchSel;

    assign tick         = (div_q == DIV_W'(DIV - 1));
    assign cmd.cmd_ready = 1'b1;
    assign rom_addr     = romAddr_q;
    assign R2R_out      = r2r_q;
    assign sample_valid = valid_q;
    assign voice_active = active_q;
    assign sum          = acc_q + addend;

    // Voice state after this cycle: OUTPUT advances phases, then any command overrides.
    always_comb begin
        phase_d  = phase_q;
        ftw_d    = ftw_q;
        wave_d   = wave_q;
        active_d = active_q;
        if (state_q == S_OUTPUT) begin
            for (int v = 0; v < VOICES; v++) begin
                if (active_q[v]) phase_d[v] = phase_q[v] + ftw_q[v];
            end
        end
        if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
                2'd0: begin
                    active_d[cmd.cmd_voice] = 1'b0;
                    phase_d[cmd.cmd_voice]  = '0;
                end
                2'd1: begin
                    active_d[cmd.cmd_voice] = 1'b1;
                    phase_d[cmd.cmd_voice]  = '0;
                    ftw_d[cmd.cmd_voice]    = cmd.cmd_data;
                end
                2'd2:    wave_d[cmd.cmd_voice] = cmd.cmd_data[2:0];
                default: ;
            endcase
        end
    end

    // Fetch addresses come from next-state voice data so same-edge commands are seen.
    always_comb begin
        fetchLoad = 1'b0;
        fetchSel  = '0;
        if (state_q == S_IDLE && tick) begin
            fetchLoad = 1'b1;
        end else if (state_q == S_FETCH && idx_q != LAST_FETCH) begin
            fetchLoad = 1'b1;
            fetchSel  = idx_q + VW'(1);
        end
    end

`ifdef DDS_VELOCITY_EN
    logic [6:0]            vel_q [VOICES];
    logic [6:0]            fetchVel_q, addVel_q;
    logic [SAMPLE_W-1:0]   prod_q;
    logic [SAMPLE_W+6:0]   prodFull;

    assign prodFull = (SAMPLE_W+7)'(rom_q) * (SAMPLE_W+7)'(addVel_q);
    assign addend   = ACC_W'(prod_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vel_q      <= '{default: '0};
            fetchVel_q <= '0;
            addVel_q   <= '0;
            prod_q     <= '0;
        end else begin
            if (cmd.cmd_valid && cmd.cmd_op == 2'd1)
                vel_q[cmd.cmd_voice] <= cmd.cmd_data[PHASE_W-1 -: 7];
            fetchVel_q <= fetchLoad ? vel_q[fetchSel] : 7'd0;
            addVel_q   <= fetchVel_q;
            prod_q     <= addAct_q ? SAMPLE_W'(prodFull >> 7) : '0;
        end
    end
`else
    assign addend = addAct_q ? ACC_W'(rom_q) : '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            phase_q    <= '{default: '0};
            ftw_q      <= '{default: '0};
            wave_q     <= '{default: '0};
            active_q   <= '0;
            acc_q      <= '0;
            r2r_q      <= '0;
            valid_q    <= 1'b0;
            romAddr_q  <= '0;
            fetchAct_q <= 1'b0;
            addAct_q   <= 1'b0;
        end else begin
            div_q    <= tick ? '0 : div_q + DIV_W'(1);
            phase_q  <= phase_d;
            ftw_q    <= ftw_d;
            wave_q   <= wave_d;
            active_q <= active_d;
            valid_q  <= 1'b0;
            addAct_q <= fetchAct_q;
            if (fetchLoad) begin
                romAddr_q  <= {wave_d[fetchSel], phase_d[fetchSel][PHASE_W-1 -: ADDR_W]};
                fetchAct_q <= active_d[fetchSel];
            end else begin
                fetchAct_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_FETCH;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                S_FETCH: begin
                    acc_q <= sum;
                    if (idx_q == LAST_FETCH) begin
                        state_q <= S_DRAIN;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + VW'(1);
                    end
                end
                S_DRAIN: begin
                    acc_q <= sum;
                    if (idx_q == LAST_DRAIN) begin
                        state_q <= S_OUTPUT;
                        r2r_q   <= sum[ACC_W-1 -: OUT_W];
                        valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + VW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_poly.sv
// Scoreboard bench for dds_poly: a cycle-level voice model predicts every fetch
// address and mixed sample; a negedge monitor pops expectations on sample_valid.
`timescale 1ns/1ps
module tb_dds_poly;
    localparam int VOICES   = 8;
    localparam int PHASE_W  = 32;
    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 24;
    localparam int OUT_W    = 8;
    localparam int DIV      = 100;
    localparam int ACC_W    = SAMPLE_W + 3;
`ifdef DDS_VELOCITY_EN
    localparam int OUTK = VOICES + 2;
`else
    localparam int OUTK = VOICES + 1;
`endif

    typedef struct {
        int                due;
        logic [OUT_W-1:0]  val;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [ADDR_W+2:0]   rom_addr;
    logic [SAMPLE_W-1:0] romQ = '0;
    logic [OUT_W-1:0]    R2R_out;
    logic                sample_valid;
    logic [VOICES-1:0]   voice_active;

    int total = 0;
    int bad   = 0;
    int romMode = 0;
    int k = 0;

    logic [PHASE_W-1:0] mPhase [VOICES];
    logic [PHASE_W-1:0] mFtw   [VOICES];
    logic [2:0]         mWave  [VOICES];
    logic               mActive[VOICES];
    int                 mVel   [VOICES];
    longint             mAcc;
    logic [ADDR_W+2:0]  expAddr;
    bit                 fetchCheck = 0;
    exp_t               sbQ[$];

    dds_poly_if #(.VOICES(VOICES), .PHASE_W(PHASE_W)) cmdIf();

    dds_poly #(
        .VOICES(VOICES), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W),
        .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .DIV(DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd(cmdIf),
        .rom_addr(rom_addr),
        .rom_q(romQ),
        .R2R_out(R2R_out),
        .sample_valid(sample_valid),
        .voice_active(voice_active)
    );

    always #5 clk = ~clk;

    function automatic logic [SAMPLE_W-1:0] romFn(input logic [ADDR_W+2:0] a);
        logic [SAMPLE_W-1:0] h;
        case (romMode)
            1: h = 24'hFFFFFF;
            2: h = SAMPLE_W'(a);
            3: h = 24'h800000;
            default: h = (SAMPLE_W'(a) * SAMPLE_W'(40503)) ^ {a, 11'h5A5};
        endcase
        return h;
    endfunction

    // External wavetable: data appears one clock after the address.
    always @(posedge clk) romQ <= romFn(rom_addr);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (t=%0t k=%0d)", name, act, exp, $time, k);
        end
    endtask

    // Reference model: k counts clocks since reset release; the divider equals k mod DIV.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < VOICES; v++) begin
                mPhase[v] = '0; mFtw[v] = '0; mWave[v] = '0; mActive[v] = 1'b0; mVel[v] = 0;
            end
            k = 0;
            mAcc = 0;
            fetchCheck = 0;
            sbQ.delete();
        end else begin
            int v;
            logic [ACC_W-1:0] accBits;
            exp_t e;
            if (k >= DIV && k % DIV == OUTK) begin
                for (int i = 0; i < VOICES; i++)
                    if (mActive[i]) mPhase[i] = mPhase[i] + mFtw[i];
            end
            if (cmdIf.cmd_valid) begin
                v = int'(cmdIf.cmd_voice);
                case (cmdIf.cmd_op)
                    2'd0: begin mActive[v] = 1'b0; mPhase[v] = '0; end
                    2'd1: begin
                        mActive[v] = 1'b1; mPhase[v] = '0; mFtw[v] = cmdIf.cmd_data;
                        mVel[v] = int'(cmdIf.cmd_data >> (PHASE_W - 7));
                    end
                    2'd2: mWave[v] = cmdIf.cmd_data[2:0];
                    default: ;
                endcase
            end
            k++;
            fetchCheck = 0;
            if (k >= DIV && k % DIV < VOICES) begin
                v = k % DIV;
                if (v == 0) mAcc = 0;
                expAddr = {mWave[v], mPhase[v][PHASE_W-1 -: ADDR_W]};
                fetchCheck = 1;
`ifdef DDS_VELOCITY_EN
                if (mActive[v]) mAcc += (longint'(romFn(expAddr)) * mVel[v]) >> 7;
`else
                if (mActive[v]) mAcc += longint'(romFn(expAddr));
`endif
            end
            if (k >= DIV && k % DIV == OUTK) begin
                accBits = mAcc[ACC_W-1:0];
                e.due = k;
                e.val = accBits[ACC_W-1 -: OUT_W];
                sbQ.push_back(e);
            end
        end
    end

    // Per-cycle checks just after the active edge.
    always @(posedge clk) begin
        logic [VOICES-1:0] va;
        #1;
        if (!reset) begin
            for (int i = 0; i < VOICES; i++) va[i] = mActive[i];
            checkOutput("voice_active", 64'(voice_active), 64'(va));
            checkOutput("cmd_ready", 64'(cmdIf.cmd_ready), 64'd1);
            if (fetchCheck) checkOutput("rom_addr", 64'(rom_addr), 64'(expAddr));
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("sample_valid_in_reset", 64'(sample_valid), 64'd0);
        end else if (sbQ.size() > 0 && sbQ[0].due == k) begin
            checkOutput("sample_valid_timing", 64'(sample_valid), 64'd1);
            checkOutput("R2R_out", 64'(R2R_out), 64'(sbQ[0].val));
            void'(sbQ.pop_front());
        end else begin
            checkOutput("sample_valid_idle", 64'(sample_valid), 64'd0);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input int voice, input logic [PHASE_W-1:0] data);
        cmdIf.cmd_valid = 1'b1;
        cmdIf.cmd_op    = op;
        cmdIf.cmd_voice = 3'(voice);
        cmdIf.cmd_data  = data;
        @(posedge clk);
        #1;
        cmdIf.cmd_valid = 1'b0;
    endtask

    task automatic waitPhase(input int target);
        bit hit = 0;
        for (int n = 0; n < 2 * DIV && !hit; n++) begin
            @(posedge clk);
            #1;
            if (k >= DIV && k % DIV == target) hit = 1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_phase_%0d: timed out", target);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("reset_sample_valid", 64'(sample_valid), 64'd0);
        checkOutput("reset_R2R_out", 64'(R2R_out), 64'd0);
        checkOutput("reset_rom_addr", 64'(rom_addr), 64'd0);
        checkOutput("reset_voice_active", 64'(voice_active), 64'd0);
        waitCycles(3);
        reset = 1'b0;
    endtask

    initial begin
        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_op    = '0;
        cmdIf.cmd_voice = '0;
        cmdIf.cmd_data  = '0;
        waitCycles(1);
        doReset();
        $display("[TB] idle sweeps");
        waitCycles(2 * DIV + 20);

        $display("[TB] voice 0 ramp");
        waitPhase(OUTK + 2);
        romMode = 2;
        applyStimulus(2'd1, 0, 32'h0040_0000);
        waitCycles(4 * DIV);

        $display("[TB] all voices full scale");
        waitPhase(OUTK + 2);
        romMode = 1;
        for (int v = 0; v < VOICES; v++) applyStimulus(2'd1, v, $urandom);
        waitCycles(2 * DIV);

        $display("[TB] voice 3 off during OUTPUT");
        waitPhase(OUTK);
        applyStimulus(2'd0, 3, 32'h0);
        checkOutput("voice3_off", 64'(voice_active[3]), 64'd0);
        waitCycles(DIV + 20);

        $display("[TB] phase wrap");
        waitPhase(OUTK + 2);
        romMode = 0;
        for (int v = 0; v < VOICES; v++) applyStimulus(2'd0, v, 32'h0);
        applyStimulus(2'd1, 5, 32'hFFFF_FFFF);
        applyStimulus(2'd2, 5, 32'h5);
        waitCycles(3 * DIV);

`ifdef DDS_VELOCITY_EN
        $display("[TB] velocity 64");
        waitPhase(OUTK + 2);
        romMode = 3;
        applyStimulus(2'd0, 5, 32'h0);
        applyStimulus(2'd1, 0, {7'd64, 25'd0});
        waitCycles(2 * DIV);
        waitPhase(OUTK + 2);
        romMode = 0;
`endif

        $display("[TB] random commands");
        repeat (250) begin
            waitCycles($urandom_range(0, 12));
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, VOICES - 1), $urandom);
        end

        $display("[TB] reset mid-sweep");
        waitPhase(3);
        doReset();
        applyStimulus(2'd1, 2, $urandom);
        waitCycles(2 * DIV + 20);

        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
